keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Sequencer for the board's 4×5 matrix keypad. It feeds the operand-entry block that assembles Ai/Bi from key codes.
- Drives the keypad rows one at a time and samples the columns.
- Debounces whole scan frames and encodes each new single-key press as a 5-bit code.
- Presents the code to the entry block on a `D_ready`/`Din`/`readn` handshake.
- Sits between the keypad pins and the entry block; it is the only driver of `D_ready`/`Din`.

## Interface
Parameters:
- `CLK_DIV`, default 100000: clocks per row interval (1 ms at 100 MHz); must be ≥ 2.
- `DEBOUNCE`, default 4: number of consecutive identical frame results required before the result is accepted; must be ≥ 1.

Ports:
- `clk`  in  1  system clock. One clock domain; no other clocks.
- `rstn`  in  1  reset, synchronous, active-low.
- `kcol`  in  5  column inputs, active-low (pulled up), already synchronised externally.
- `readn`  in  1  consume strobe from the entry block; a cycle with `readn`=0 and `D_ready`=1 consumes the code.
- `krow`  out  4  row drives, active-low; at most one bit low at any time.
- `D_ready`  out  1  `Din` holds an unconsumed key code.
- `Din`  out  5  key code, `row*5 + col`, range 0–19.
- `lost`  out  1  one-cycle pulse: a press was accepted while the previous code was still unconsumed.

## Operation
- **Reset values:** `krow`=4'b1111, `D_ready`=0, `Din`=0, `lost`=0, row index=0, divider=0, debounce count=0, stable result=NONE, armed=1.
- **Scan FSM** (states DRIVE, SAMPLE, EVAL):
  - DRIVE: `krow` has bit `r` low. The divider counts 0..CLK_DIV-1.
  - SAMPLE: entered on divider = CLK_DIV-1. `~kcol` is ORed into the frame accumulator for row `r`. Then `r` increments; if `r` was 3, go to EVAL, else go to DRIVE.
  - EVAL: lasts one cycle, with `krow`=4'b1111. It classifies the frame:
    - NONE: no bit set.
    - KEY(code): exactly one bit set across all 20 positions.
    - MULTI: more than one bit set.
    
    It then clears the accumulator, sets `r`=0, and returns to DRIVE.
- **Debounce:**
  - If the frame result equals the previous frame result, the debounce count increments, saturating at DEBOUNCE. Otherwise the count is reset to 1.
  - When the count reaches DEBOUNCE, the result becomes the stable result.
- **Press events:**
  - A press fires when the stable result becomes KEY(c) while armed=1. Firing clears armed.
  - A stable NONE sets armed=1.
  - A stable MULTI never fires and never re-arms. There is no auto-repeat; a key must be released before it can fire again.
- **Handshake:**
  - On a press: `Din`←c and `D_ready`←1.
  - If `D_ready` was already 1 at that moment, `lost` pulses and the new code overwrites the old one.
  - Consume: `readn`=0 while `D_ready`=1 → `D_ready`=0 on the next cycle.
  - `Din` holds its value after consume.
- **Simultaneous press and consume in the same cycle:** the press wins. `Din`←new code, `D_ready` stays 1, and `lost` does not pulse because the old code was consumed.
- **Reset mid-frame:** all state returns to reset values on the next edge, and the partial frame is discarded.

## Timing
- Row interval is CLK_DIV cycles; a frame is 4·CLK_DIV+1 cycles including EVAL.
- Each row is driven for CLK_DIV cycles before it is sampled, which gives the column lines time to settle.
- Press latency: `D_ready` rises on the cycle after the EVAL in which the debounce count reaches DEBOUNCE. A clean press is therefore recognised within DEBOUNCE+1 frames.
- `krow` changes only on divider wrap or on entry to/exit from EVAL.
- `readn` is sampled every cycle; there is no minimum low width.

## Structure
- **Shared package `keypad_pkg`:**
  - Constants KEY_ROWS=4, KEY_COLS=5, KEY_CODE_W=5.
  - State enum {DRIVE, SAMPLE, EVAL}.
  - Result encoding {NONE, KEY, MULTI}.
- **Sub-module `scan_tick_gen`:** the CLK_DIV divider, producing a one-cycle `tick` at CLK_DIV-1; synchronous reset with `rstn`.
- **Top-level contents:** FSM, frame accumulator, classifier, debouncer, and handshake register.

## Test plan
Bench parameters: CLK_DIV=4, DEBOUNCE=2.
- Reset held 3 cycles with keys pressed → `krow`=1111, `D_ready`=0, `Din`=0 throughout; row 0 driven (1110) on the first cycle after release.
- Key row 2, col 3 held steady → `D_ready`=1, `Din`=13 within 3 frames; `readn` low for 1 cycle → `D_ready`=0 on the next cycle; key still held → no second event.
- Bouncing press (key 7 toggling every frame for 3 frames, then stable) → exactly one event, `Din`=7, no event during the bounce.
- Keys 0 and 19 held together → no event; release key 19 leaving key 0 → still no event (not armed); release all, then press key 0 → `Din`=0, `D_ready`=1.
- Press key 5, do not consume, release, press key 9 → `lost` pulses one cycle, `Din`=9, `D_ready` remains 1.
- Key 4 press event coincident with `readn`=0 on an old pending code → `Din`=4, `D_ready`=1, `lost`=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x5 matrix keypad scanner.
//   - Keypad geometry and key-code width.
//   - Scan FSM state enum (DRIVE, SAMPLE, EVAL).
//   - Frame result encoding (NONE, KEY, MULTI) and a frame classifier.
package keypad_pkg;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 5;
    localparam int KEY_CODE_W = 5;
    localparam int KEY_COUNT  = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {
        DRIVE,
        SAMPLE,
        EVAL
    } scan_state_e;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } result_kind_e;

    // The code field is forced to zero unless the kind is KEY, so two
    // results can be compared directly with == for debouncing.
    typedef struct packed {
        result_kind_e            kind;
        logic [KEY_CODE_W-1:0]   code;
    } frame_result_t;

    localparam frame_result_t RESULT_NONE = '{kind: NONE, code: '0};

    // Classifies one complete scan frame (bit index = row*KEY_COLS + col).
    function automatic frame_result_t classify_frame(input logic [KEY_COUNT-1:0] frame);
        frame_result_t res;
        int unsigned   hits;
        res  = RESULT_NONE;
        hits = 0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (frame[i]) begin
                hits++;
                res.code = KEY_CODE_W'(i);
            end
        end
        if (hits == 1) begin
            res.kind = KEY;
        end else if (hits > 1) begin
            res.kind = MULTI;
            res.code = '0;
        end else begin
            res.kind = NONE;
            res.code = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_tick_gen.sv
// scan_tick_gen
// Row-interval divider for the keypad scanner. Counts 0..CLK_DIV-1 while
// enabled and wraps; holds its value while disabled.
// Ports:
//   clk        in   system clock
//   rstn       in   synchronous active-low reset (count returns to 0)
//   en         in   count enable
//   tick       out  high while the count is CLK_DIV-1 (one cycle per interval)
//   tick_next  out  high while the count is CLK_DIV-2, i.e. one cycle ahead
//                   of tick, so a registered FSM can land in its sample
//                   state exactly on the tick cycle
module scan_tick_gen #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic tick,
    output logic tick_next
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick      = en && (count_q == LAST);
    assign tick_next = en && (count_q == PRE_LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans the 4x5 matrix keypad one row at a time, debounces whole frames,
// and hands each new single-key press to the operand-entry block.
// Ports:
//   clk      in   system clock
//   rstn     in   synchronous active-low reset
//   kcol     in   column inputs, active-low, already synchronised
//   readn    in   consume strobe (low while D_ready=1 consumes the code)
//   krow     out  row drives, active-low, at most one bit low
//   D_ready  out  Din holds an unconsumed key code
//   Din      out  key code row*5+col (0..19), held after consume
//   lost     out  one-cycle pulse when a press overwrote an unconsumed code
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_DIV  = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [KEY_COLS-1:0]   kcol,
    input  logic                  readn,
    output logic [KEY_ROWS-1:0]   krow,
    output logic                  D_ready,
    output logic [KEY_CODE_W-1:0] Din,
    output logic                  lost
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE);

    scan_state_e           state_q, state_d;
    logic [1:0]            row_q, row_d;
    logic [KEY_COUNT-1:0]  acc_q, acc_d;
    frame_result_t         prev_q, prev_d;
    frame_result_t         stable_q, stable_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [KEY_ROWS-1:0]   krow_q, krow_d;
    logic                  d_ready_q, d_ready_d;
    logic [KEY_CODE_W-1:0] din_q, din_d;
    logic                  lost_q, lost_d;

    frame_result_t         frame_res;
    logic                  fire;
    logic                  consume;
    logic                  tick;
    logic                  tick_next;

    // The divider is frozen during EVAL (it has just wrapped to 0), so every
    // row gets a full CLK_DIV interval and a frame is 4*CLK_DIV+1 cycles.
    scan_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rstn      (rstn),
        .en        (state_q != EVAL),
        .tick      (tick),
        .tick_next (tick_next)
    );

    // Next-state logic for the scan FSM, frame accumulator, debouncer and
    // handshake register. A press is decided in EVAL, so D_ready and lost
    // show it on the cycle after EVAL.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        d_ready_d = d_ready_q;
        din_d     = din_q;
        lost_d    = 1'b0;
        fire      = 1'b0;
        frame_res = classify_frame(acc_q);
        consume   = !readn && d_ready_q;

        case (state_q)
            DRIVE: begin
                if (tick_next) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (tick) begin
                    acc_d[int'(row_q)*KEY_COLS +: KEY_COLS] =
                        acc_q[int'(row_q)*KEY_COLS +: KEY_COLS] | ~kcol;
                    row_d   = row_q + 2'd1;
                    state_d = (row_q == 2'd3) ? EVAL : DRIVE;
                end
            end
            EVAL: begin
                if (frame_res == prev_q) begin
                    cnt_d = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = CNT_W'(1);
                end
                prev_d = frame_res;
                // Only a debounced result affects arming/firing. A stable
                // MULTI leaves armed untouched; a key must pass through a
                // stable NONE before it can fire again.
                if (cnt_d == DB_MAX) begin
                    stable_d = frame_res;
                    if (frame_res.kind == NONE) begin
                        armed_d = 1'b1;
                    end else if (frame_res.kind == KEY && armed_q &&
                                 stable_q != frame_res) begin
                        fire    = 1'b1;
                        armed_d = 1'b0;
                    end
                end
                acc_d   = '0;
                row_d   = 2'd0;
                state_d = DRIVE;
            end
            default: begin
                state_d = DRIVE;
            end
        endcase

        // A press beats a same-cycle consume; lost only flags a code that
        // was overwritten without having been read.
        if (fire) begin
            din_d     = frame_res.code;
            d_ready_d = 1'b1;
            lost_d    = d_ready_q && !consume;
        end else if (consume) begin
            d_ready_d = 1'b0;
        end

        krow_d = (state_d == EVAL) ? '1 : ~(KEY_ROWS'(1) << row_d);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= DRIVE;
            row_q     <= 2'd0;
            acc_q     <= '0;
            prev_q    <= RESULT_NONE;
            stable_q  <= RESULT_NONE;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            krow_q    <= '1;
            d_ready_q <= 1'b0;
            din_q     <= '0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            krow_q    <= krow_d;
            d_ready_q <= d_ready_d;
            din_q     <= din_d;
            lost_q    <= lost_d;
        end
    end

    assign krow    = krow_q;
    assign D_ready = d_ready_q;
    assign Din     = din_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Self-checking bench for keypad_scan_ctrl with CLK_DIV=4, DEBOUNCE=2.
// A keypad matrix model turns the set of held keys into column levels from
// the row drive. A cycle-counting reference model predicts krow, D_ready,
// Din and lost from the frame schedule and the debounce/arming rules.
module tb_keypad_scan_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 4 * CLK_DIV + 1;
    localparam int EVAL_PH  = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        readn = 1'b1;
    logic [4:0]  kcol;
    logic [3:0]  krow;
    logic        D_ready;
    logic [4:0]  Din;
    logic        lost;

    logic [19:0] pressed = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_valid = 1'b0;
    int          m_cyc;
    logic [19:0] m_acc;
    int          m_prev;
    int          m_cnt;
    bit          m_armed;
    bit          m_ready;
    int          m_din;
    bit          m_lost;
    logic [3:0]  m_krow;
    bit          m_fired;
    bit          m_consume;
    int          m_phase;
    int          m_res;

    // Observed event counters
    int  rise_cnt = 0;
    int  lost_cnt = 0;
    bit  prev_ready = 1'b0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .kcol    (kcol),
        .readn   (readn),
        .krow    (krow),
        .D_ready (D_ready),
        .Din     (Din),
        .lost    (lost)
    );

    // Physical keypad: a held key pulls its column low while its row is driven.
    always_comb begin
        kcol = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (!krow[r] && pressed[r*5+c]) begin
                    kcol[c] = 1'b0;
                end
            end
        end
    end

    // -1 = no key, 0..19 = single key, 100 = several keys
    function automatic int frameResult(input logic [19:0] f);
        int ones;
        ones = $countones(f);
        if (ones == 0) return -1;
        if (ones > 1) return 100;
        for (int i = 0; i < 20; i++) begin
            if (f[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [19:0] rowMask(input int r);
        logic [19:0] m;
        m = 20'h1F;
        return m << (r * 5);
    endfunction

    function automatic logic [3:0] rowDrive(input int cyc);
        logic [3:0] one;
        int ph;
        one = 4'b0001;
        ph  = cyc % FRAME;
        if (ph == EVAL_PH) return 4'hF;
        return ~(one << (ph / CLK_DIV));
    endfunction

    // True when the current cycle is an evaluation that will fire a press.
    function automatic bit wouldFire();
        int res;
        int nc;
        if (!m_valid || !rstn || (m_cyc % FRAME) != EVAL_PH) return 1'b0;
        res = frameResult(m_acc);
        nc  = (res == m_prev) ? ((m_cnt < DEBOUNCE) ? m_cnt + 1 : DEBOUNCE) : 1;
        return (nc == DEBOUNCE) && (res >= 0) && (res < 20) && m_armed;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model, advanced once per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            m_valid = 1'b1;
            if (!rstn) begin
                m_cyc   = 0;
                m_acc   = '0;
                m_prev  = -1;
                m_cnt   = 0;
                m_armed = 1'b1;
                m_ready = 1'b0;
                m_din   = 0;
                m_lost  = 1'b0;
                m_krow  = 4'hF;
            end else begin
                m_phase   = m_cyc % FRAME;
                m_consume = !readn && m_ready;
                m_lost    = 1'b0;
                m_fired   = 1'b0;
                if (m_phase < EVAL_PH && (m_phase % CLK_DIV) == CLK_DIV - 1) begin
                    m_acc = m_acc | (pressed & rowMask(m_phase / CLK_DIV));
                end else if (m_phase == EVAL_PH) begin
                    m_res  = frameResult(m_acc);
                    m_cnt  = (m_res == m_prev) ? ((m_cnt < DEBOUNCE) ? m_cnt + 1 : DEBOUNCE) : 1;
                    m_prev = m_res;
                    m_acc  = '0;
                    if (m_cnt == DEBOUNCE) begin
                        if (m_res == -1) begin
                            m_armed = 1'b1;
                        end else if (m_res < 20 && m_armed) begin
                            m_fired = 1'b1;
                            m_armed = 1'b0;
                        end
                    end
                end
                if (m_fired) begin
                    m_lost  = m_ready && !m_consume;
                    m_din   = m_res;
                    m_ready = 1'b1;
                end else if (m_consume) begin
                    m_ready = 1'b0;
                end
                m_cyc  = m_cyc + 1;
                m_krow = rowDrive(m_cyc);
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                checkOutput("krow", int'(krow), int'(m_krow));
                checkOutput("D_ready", int'(D_ready), int'(m_ready));
                checkOutput("Din", int'(Din), m_din);
                checkOutput("lost", int'(lost), int'(m_lost));
                if (D_ready && !prev_ready) rise_cnt++;
                if (lost) lost_cnt++;
                prev_ready = D_ready;
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [19:0] keys, input int frames);
        pressed = keys;
        stepCycles(frames * FRAME);
    endtask

    task automatic pulseRead();
        readn = 1'b0;
        stepCycles(1);
        readn = 1'b1;
    endtask

    task automatic waitFrameStart();
        for (int i = 0; i < FRAME && (m_cyc % FRAME) != 0; i++) begin
            stepCycles(1);
        end
    endtask

    function automatic logic [19:0] keyBit(input int k);
        logic [19:0] one;
        one = 20'd1;
        return one << k;
    endfunction

    int base_ev;
    int base_lost;
    int waited;
    int hold;
    int kind;

    initial begin
        // Reset held with key 13 (row 2, col 3) already pressed.
        pressed = keyBit(13);
        rstn    = 1'b0;
        readn   = 1'b1;
        repeat (3) begin
            stepCycles(1);
            checkOutput("reset_krow", int'(krow), 15);
            checkOutput("reset_ready", int'(D_ready), 0);
            checkOutput("reset_din", int'(Din), 0);
        end
        rstn = 1'b1;
        stepCycles(1);
        checkOutput("first_row", int'(krow), 14);

        // Steady press of key 13.
        waited = 0;
        while (!D_ready && waited < 3 * FRAME) begin
            stepCycles(1);
            waited++;
        end
        checkOutput("press13_ready", int'(D_ready), 1);
        checkOutput("press13_din", int'(Din), 13);
        pulseRead();
        checkOutput("consume_ready", int'(D_ready), 0);
        base_ev = rise_cnt + lost_cnt;
        applyStimulus(keyBit(13), 3);
        checkOutput("no_repeat_events", rise_cnt + lost_cnt - base_ev, 0);

        // Bouncing press of key 7, one toggle per frame.
        applyStimulus('0, 3);
        waitFrameStart();
        base_ev = rise_cnt + lost_cnt;
        applyStimulus(keyBit(7), 1);
        applyStimulus('0, 1);
        applyStimulus(keyBit(7), 1);
        checkOutput("bounce_quiet", rise_cnt + lost_cnt - base_ev, 0);
        applyStimulus(keyBit(7), 3);
        checkOutput("bounce_events", rise_cnt + lost_cnt - base_ev, 1);
        checkOutput("bounce_din", int'(Din), 7);
        pulseRead();

        // Two keys together, then one of them left held: no press while disarmed.
        base_ev = rise_cnt + lost_cnt;
        applyStimulus(keyBit(0) | keyBit(19), 3);
        checkOutput("multi_events", rise_cnt + lost_cnt - base_ev, 0);
        applyStimulus(keyBit(0), 3);
        checkOutput("disarmed_events", rise_cnt + lost_cnt - base_ev, 0);
        applyStimulus('0, 3);
        applyStimulus(keyBit(0), 3);
        checkOutput("rearm_events", rise_cnt + lost_cnt - base_ev, 1);
        checkOutput("rearm_din", int'(Din), 0);
        checkOutput("rearm_ready", int'(D_ready), 1);
        pulseRead();

        // Unread key 5 overwritten by key 9.
        applyStimulus('0, 3);
        base_lost = lost_cnt;
        applyStimulus(keyBit(5), 3);
        applyStimulus('0, 3);
        applyStimulus(keyBit(9), 3);
        checkOutput("lost_pulses", lost_cnt - base_lost, 1);
        checkOutput("lost_din", int'(Din), 9);
        checkOutput("lost_ready", int'(D_ready), 1);

        // Key 4 press lands on the same cycle the pending key 9 is consumed.
        applyStimulus('0, 3);
        base_lost = lost_cnt;
        pressed = keyBit(4);
        waited = 0;
        while (!wouldFire() && waited < 4 * FRAME) begin
            stepCycles(1);
            waited++;
        end
        checkOutput("coincide_found", int'(wouldFire()), 1);
        readn = 1'b0;
        stepCycles(1);
        readn = 1'b1;
        checkOutput("coincide_din", int'(Din), 4);
        checkOutput("coincide_ready", int'(D_ready), 1);
        checkOutput("coincide_lost", int'(lost), 0);
        checkOutput("coincide_lost_count", lost_cnt - base_lost, 0);
        pulseRead();

        // Random key patterns and read strobes, with one mid-frame reset.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                pressed = '0;
            end else if (kind == 3) begin
                pressed = keyBit($urandom_range(0, 19)) | keyBit($urandom_range(0, 19));
            end else begin
                pressed = keyBit($urandom_range(0, 19));
            end
            hold = $urandom_range(10, 70);
            for (int c = 0; c < hold; c++) begin
                readn = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
                stepCycles(1);
            end
            if (it == 30) begin
                stepCycles($urandom_range(1, FRAME));
                rstn = 1'b0;
                stepCycles(2);
                rstn = 1'b1;
            end
        end
        readn = 1'b1;
        stepCycles(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
